sweep_ctrl: RTL and testbench

SWEEP_CTRL -- requirements
Module: sweep_ctrl

---
 rtl/sweep_ctrl.sv | 134 +++++++++++++
 tb/tb_sweep_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: stepped-frequency sweep sequencer for a DDS.
// Emits a phase increment m per tone, a one-cycle set strobe when a new tone
// is loaded, and holds each tone for cfg_dwell+1 cycles. All outputs registered.
module sweep_ctrl #(
  parameter int M_W     = 40,
  parameter int DWELL_W = 24,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [M_W-1:0]     cfg_start,
  input  logic [M_W-1:0]     cfg_step,
  input  logic               cfg_down,
  input  logic [CNT_W-1:0]   cfg_count,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               start,
  input  logic               abort,
  output logic [M_W-1:0]     m,
  output logic               set,
  output logic               en,
  output logic               busy,
  output logic               done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nxt;
  logic [M_W-1:0]     m_nxt;
  logic               set_nxt, en_nxt, busy_nxt, done_nxt;
  logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_nxt;
  logic [CNT_W-1:0]   remaining, remaining_nxt;

  // Shadow copies of the sweep config; cfg_start and cfg_count are consumed
  // directly into m and remaining, so only the per-tone terms need holding.
  logic [M_W-1:0]     sh_step, sh_step_nxt;
  logic               sh_down, sh_down_nxt;
  logic [DWELL_W-1:0] sh_dwell, sh_dwell_nxt;

  // Next tone, modulo 2^M_W in both directions (wrap is intentional).
  logic [M_W-1:0]     m_next_tone;
  assign m_next_tone = sh_down ? (m - sh_step) : (m + sh_step);

  // Next-state and output decode; abort outranks start and dwell expiry.
  always_comb begin
    state_nxt     = state;
    m_nxt         = m;
    set_nxt       = 1'b0;
    done_nxt      = 1'b0;
    en_nxt        = en;
    busy_nxt      = busy;
    dwell_cnt_nxt = dwell_cnt;
    remaining_nxt = remaining;
    sh_step_nxt   = sh_step;
    sh_down_nxt   = sh_down;
    sh_dwell_nxt  = sh_dwell;
    case (state)
      IDLE: begin
        if (abort) begin
          en_nxt = 1'b0;
        end else if (start) begin
          if (cfg_count == '0) begin
            // Empty sweep: just report completion, outputs untouched.
            done_nxt = 1'b1;
          end else begin
            sh_step_nxt   = cfg_step;
            sh_down_nxt   = cfg_down;
            sh_dwell_nxt  = cfg_dwell;
            m_nxt         = cfg_start;
            set_nxt       = 1'b1;
            en_nxt        = 1'b1;
            busy_nxt      = 1'b1;
            dwell_cnt_nxt = cfg_dwell;
            remaining_nxt = cfg_count - 1'b1;
            state_nxt     = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          // Mute and drop the sweep; m keeps the last tone.
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          en_nxt    = 1'b0;
        end else if (dwell_cnt == '0) begin
          if (remaining != '0) begin
            m_nxt         = m_next_tone;
            set_nxt       = 1'b1;
            dwell_cnt_nxt = sh_dwell;
            remaining_nxt = remaining - 1'b1;
          end else begin
            // Last tone keeps playing after completion.
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end
        end else begin
          // Counting runs on the set cycle too, giving a dwell+1 tone period.
          dwell_cnt_nxt = dwell_cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; async reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      m         <= '0;
      set       <= 1'b0;
      en        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dwell_cnt <= '0;
      remaining <= '0;
      sh_step   <= '0;
      sh_down   <= 1'b0;
      sh_dwell  <= '0;
    end else begin
      state     <= state_nxt;
      m         <= m_nxt;
      set       <= set_nxt;
      en        <= en_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      dwell_cnt <= dwell_cnt_nxt;
      remaining <= remaining_nxt;
      sh_step   <= sh_step_nxt;
      sh_down   <= sh_down_nxt;
      sh_dwell  <= sh_dwell_nxt;
    end
  end

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb_sweep_ctrl: directed stimulus, a cycle-indexed sweep model, and a
// per-cycle compare on the falling edge plus literal spot checks.
module tb_sweep_ctrl;

  localparam int M_W = 40, DWELL_W = 24, CNT_W = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [M_W-1:0]     cfg_start = '0, cfg_step = '0;
  logic               cfg_down = 1'b0;
  logic [CNT_W-1:0]   cfg_count = '0;
  logic [DWELL_W-1:0] cfg_dwell = '0;
  logic               start = 1'b0, abort = 1'b0;
  logic [M_W-1:0]     m;
  logic               set, en, busy, done;

  int n_cmp = 0, n_err = 0;
  bit cmp_en = 1'b0;

  sweep_ctrl #(.M_W(M_W), .DWELL_W(DWELL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_step(cfg_step),
    .cfg_down(cfg_down), .cfg_count(cfg_count), .cfg_dwell(cfg_dwell),
    .start(start), .abort(abort), .m(m), .set(set), .en(en), .busy(busy),
    .done(done));

  always #5 clk = ~clk;

  // Model: a sweep accepted at edge t0 has tone k set at t0 + k*P (P=dwell+1),
  // m = start +/- k*step, and done at t0 + N*P.
  int             cyc = 0;
  bit             sw_act = 1'b0;
  int             sw_t0, sw_n, sw_p;
  logic [M_W-1:0] sw_start, sw_step;
  logic           sw_down;
  logic [M_W-1:0] e_m = '0;
  logic           e_set = 1'b0, e_en = 1'b0, e_busy = 1'b0, e_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_act = 1'b0; e_m = '0; e_set = 1'b0; e_en = 1'b0;
      e_busy = 1'b0; e_done = 1'b0;
    end else begin
      int idx;
      logic [M_W-1:0] k;
      cyc++;
      e_set = 1'b0; e_done = 1'b0;
      if (abort) begin
        sw_act = 1'b0; e_busy = 1'b0; e_en = 1'b0;
      end else if (sw_act) begin
        idx = cyc - sw_t0;
        if (idx < sw_n * sw_p) begin
          if (idx % sw_p == 0) begin
            k = M_W'(idx / sw_p);
            e_set = 1'b1;
            e_m = sw_down ? sw_start - k * sw_step : sw_start + k * sw_step;
          end
        end else begin
          e_done = 1'b1; e_busy = 1'b0; sw_act = 1'b0;
        end
      end else if (start) begin
        if (cfg_count == '0) e_done = 1'b1;
        else begin
          sw_act = 1'b1; sw_t0 = cyc; sw_n = int'(cfg_count);
          sw_p = int'(cfg_dwell) + 1; sw_start = cfg_start;
          sw_step = cfg_step; sw_down = cfg_down;
          e_set = 1'b1; e_m = cfg_start; e_en = 1'b1; e_busy = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      n_cmp += 6;
      if (m !== e_m) begin n_err++; $display("FAIL cyc%0d m got %0h want %0h", cyc, m, e_m); end
      if (set !== e_set) begin n_err++; $display("FAIL cyc%0d set got %0b want %0b", cyc, set, e_set); end
      if (en !== e_en) begin n_err++; $display("FAIL cyc%0d en got %0b want %0b", cyc, en, e_en); end
      if (busy !== e_busy) begin n_err++; $display("FAIL cyc%0d busy got %0b want %0b", cyc, busy, e_busy); end
      if (done !== e_done) begin n_err++; $display("FAIL cyc%0d done got %0b want %0b", cyc, done, e_done); end
      if (set === 1'b1 && done === 1'b1) begin n_err++; $display("FAIL cyc%0d set_and_done got 1 want 0", cyc); end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic cfg_up();
    cfg_start = 40'd40315426; cfg_step = 40'd916260; cfg_down = 1'b0;
    cfg_count = 16'd3; cfg_dwell = 24'd4;
  endtask

  // Plain up sweep with literal expectations at each tone and at done.
  task automatic run_up(input string tag);
    cfg_up();
    pulse_start();                                   // T+1
    chk({tag, "_t1_m"}, 64'(m), 64'd40315426);
    chk({tag, "_t1_set"}, 64'(set), 64'd1);
    tick(5);                                         // T+6
    chk({tag, "_t6_m"}, 64'(m), 64'd41231686);
    chk({tag, "_t6_set"}, 64'(set), 64'd1);
    tick(5);                                         // T+11
    chk({tag, "_t11_m"}, 64'(m), 64'd42147946);
    tick(4);                                         // T+15
    chk({tag, "_t15_busy"}, 64'(busy), 64'd1);
    tick(1);                                         // T+16
    chk({tag, "_t16_done"}, 64'(done), 64'd1);
    chk({tag, "_t16_busy"}, 64'(busy), 64'd0);
    chk({tag, "_t16_en"}, 64'(en), 64'd1);
    tick(1);
    chk({tag, "_t17_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    // Reset state
    tick(3);
    cmp_en = 1'b1;
    chk("rst_m", 64'(m), 64'd0);
    chk("rst_en", 64'(en), 64'd0);
    rst_n = 1'b1;
    tick(2);

    run_up("up");

    // Empty sweep: done only, last tone untouched
    cfg_count = '0;
    pulse_start();
    chk("cnt0_done", 64'(done), 64'd1);
    chk("cnt0_m", 64'(m), 64'd42147946);
    chk("cnt0_en", 64'(en), 64'd1);
    tick(1);
    chk("cnt0_done_off", 64'(done), 64'd0);

    // Abort in idle mutes only
    abort = 1'b1; tick(1); abort = 1'b0;
    chk("idle_abort_en", 64'(en), 64'd0);
    chk("idle_abort_m", 64'(m), 64'd42147946);
    tick(2);

    // Sweep with start pulses and cfg churn mid-run
    cfg_up();
    pulse_start();                                   // T+1
    tick(2);                                         // T+3
    cfg_start = 40'd7; cfg_step = 40'd5; cfg_dwell = '0;
    cfg_count = 16'd9; cfg_down = 1'b1;
    pulse_start();                                   // T+4
    tick(4);                                         // T+8
    pulse_start();                                   // T+9
    tick(2);                                         // T+11
    chk("churn_t11_m", 64'(m), 64'd42147946);
    tick(5);                                         // T+16
    chk("churn_t16_done", 64'(done), 64'd1);
    tick(2);

    // Abort with simultaneous start mid-sweep
    cfg_up();
    pulse_start();                                   // T+1
    tick(6);                                         // T+7
    abort = 1'b1; start = 1'b1;
    tick(1);                                         // T+8
    abort = 1'b0; start = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_en", 64'(en), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_m", 64'(m), 64'd41231686);
    tick(12);
    chk("abort_m_hold", 64'(m), 64'd41231686);

    // Abort landing on the final expiry suppresses done
    cfg_count = 16'd1; cfg_dwell = 24'd2;
    pulse_start();                                   // T+1
    tick(2);                                         // T+3 expiry
    abort = 1'b1; tick(1); abort = 1'b0;
    chk("abort_exp_done", 64'(done), 64'd0);
    tick(3);

    // Wrap up, then wrap down
    cfg_start = 40'hFF_FFFF_FFFF; cfg_step = 40'd2; cfg_down = 1'b0;
    cfg_count = 16'd2; cfg_dwell = '0;
    pulse_start();
    chk("wrap_t1_m", 64'(m), 64'hFF_FFFF_FFFF);
    tick(1);
    chk("wrap_t2_m", 64'(m), 64'h1);
    chk("wrap_t2_set", 64'(set), 64'd1);
    tick(1);
    chk("wrap_t3_done", 64'(done), 64'd1);
    cfg_start = 40'd1; cfg_step = 40'd3; cfg_down = 1'b1;
    pulse_start();
    chk("down_t1_m", 64'(m), 64'h1);
    tick(1);
    chk("down_t2_m", 64'(m), 64'hFF_FFFF_FFFE);
    tick(3);

    // Reset mid-sweep, mid-cycle, then a fresh sweep
    cfg_up();
    pulse_start();                                   // T+1
    tick(7);                                         // T+8
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_m", 64'(m), 64'd0);
    chk("mrst_en", 64'(en), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_set_done", 64'({set, done}), 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("post_rst_m", 64'(m), 64'd0);
    run_up("again");
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
